// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, interface configuration
// record and the byte-strobe merge helper used by register slaves.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest data path the merge helper supports; callers cast to their width.
  localparam int unsigned STRB_MAX_W = 128;
  localparam int unsigned DATA_MAX_W = STRB_MAX_W * 8;

  // Zero in a field means "not specified".
  typedef struct packed {
    logic [31:0] a_w;
    logic [31:0] d_w;
  } axi4_lite_cfg_t;

  // Replace each byte of old_d whose strobe bit is set with the byte of new_d.
  function automatic logic [DATA_MAX_W-1:0] strb_merge(
    input logic [DATA_MAX_W-1:0] old_d,
    input logic [DATA_MAX_W-1:0] new_d,
    input logic [STRB_MAX_W-1:0] strb
  );
    logic [DATA_MAX_W-1:0] merged;
    merged = old_d;
    for (int b = 0; b < int'(STRB_MAX_W); b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_d[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master/slave views.
interface axi4_lite_if #(
  parameter int unsigned A_W = 32,
  parameter int unsigned D_W = 32
);

  logic             awvalid;
  logic             awready;
  logic [A_W-1:0]   awaddr;
  logic             wvalid;
  logic             wready;
  logic [D_W-1:0]   wdata;
  logic [D_W/8-1:0] wstrb;
  logic             bvalid;
  logic             bready;
  logic [1:0]       bresp;
  logic             arvalid;
  logic             arready;
  logic [A_W-1:0]   araddr;
  logic             rvalid;
  logic             rready;
  logic [D_W-1:0]   rdata;
  logic [1:0]       rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_wr_join.sv
// AXI4-Lite write join: single-entry AW and W holds, commit generation and
// the B channel. The parent decodes o_addr and returns i_slverr.
//   aclk, aresetn          clock, async active-low reset
//   i_aw*/o_awready        write address channel
//   i_w*/o_wready          write data channel
//   o_bvalid/i_bready/o_bresp  write response channel
//   i_slverr               decode error for the held address
//   o_commit_c             held pair is written this cycle
//   o_addr/o_data/o_strb   held write payload
module axi4_lite_wr_join
  import axi4_lite_pkg::*;
#(
  parameter int unsigned A_W = 32,
  parameter int unsigned D_W = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             i_awvalid,
  output logic             o_awready,
  input  logic [A_W-1:0]   i_awaddr,
  input  logic             i_wvalid,
  output logic             o_wready,
  input  logic [D_W-1:0]   i_wdata,
  input  logic [D_W/8-1:0] i_wstrb,
  output logic             o_bvalid,
  input  logic             i_bready,
  output logic [1:0]       o_bresp,
  input  logic             i_slverr,
  output logic             o_commit_c,
  output logic [A_W-1:0]   o_addr,
  output logic [D_W-1:0]   o_data,
  output logic [D_W/8-1:0] o_strb
);

  localparam int unsigned S_W = D_W / 8;

  logic           r_aw_held;
  logic           r_w_held;
  logic [A_W-1:0] r_awaddr;
  logic [D_W-1:0] r_wdata;
  logic [S_W-1:0] r_wstrb;
  logic           r_bvalid;
  logic [1:0]     r_bresp;
  logic           w_aw_hs;
  logic           w_w_hs;
  logic           w_commit;

  // Readys come straight from the hold flags, gated low during reset.
  assign o_awready = aresetn & ~r_aw_held;
  assign o_wready  = aresetn & ~r_w_held;
  assign w_aw_hs   = i_awvalid & o_awready;
  assign w_w_hs    = i_wvalid & o_wready;

  // A new response may be issued while the previous one is being accepted.
  assign w_commit  = r_aw_held & r_w_held & (~r_bvalid | i_bready);

  // Address hold.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_held <= 1'b0;
      r_awaddr  <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
    end else if (w_aw_hs) begin
      r_aw_held <= 1'b1;
      r_awaddr  <= i_awaddr;
    end
  end

  // Data hold.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_w_held <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else if (w_commit) begin
      r_w_held <= 1'b0;
    end else if (w_w_hs) begin
      r_w_held <= 1'b1;
      r_wdata  <= i_wdata;
      r_wstrb  <= i_wstrb;
    end
  end

  // Write response channel.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= i_slverr ? RESP_SLVERR : RESP_OKAY;
    end else if (i_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  assign o_bvalid   = r_bvalid;
  assign o_bresp    = r_bresp;
  assign o_commit_c = w_commit;
  assign o_addr     = r_awaddr;
  assign o_data     = r_wdata;
  assign o_strb     = r_wstrb;

endmodule

// File: rtl/axi4_lite_reg_file.sv
// AXI4-Lite slave register bank: N_REGS word registers, each either
// software-writable (with byte strobes) or a read-only view of reg_d.
//   aclk, aresetn  clock, async active-low reset
//   axi4_s         AXI4-Lite slave port
//   reg_q          register contents, slice i = register i (read-only slots 0)
//   reg_d          status inputs returned by read-only registers
//   wr_stb         one-cycle pulse per committed write to a writable register
module axi4_lite_reg_file
  import axi4_lite_pkg::*;
#(
  parameter axi4_lite_cfg_t              C         = '{default: 0},
  parameter int unsigned                 A_W       = 32,
  parameter int unsigned                 D_W       = 32,
  parameter int unsigned                 N_REGS    = 8,
  parameter logic [N_REGS-1:0]           RO_MASK   = '0,
  parameter logic [N_REGS*D_W-1:0]       RESET_VAL = '0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi4_lite_if.slave            axi4_s,
  output logic [N_REGS*D_W-1:0] reg_q,
  input  logic [N_REGS*D_W-1:0] reg_d,
  output logic [N_REGS-1:0]     wr_stb
);

  localparam int unsigned S_W      = D_W / 8;
  localparam int unsigned LSB      = $clog2(S_W);
  localparam int unsigned IDX_W    = $clog2(N_REGS);
  localparam int unsigned HI_SHIFT = LSB + IDX_W;

  // Reject configurations that disagree with the bus or the address map.
  if ((C.a_w != 0 && C.a_w != A_W) || (C.d_w != 0 && C.d_w != D_W) ||
      (D_W % 8 != 0) || (N_REGS < 2) || (N_REGS > 256) ||
      ((N_REGS & (N_REGS - 1)) != 0)) begin : g_cfg_err
    $error("axi4_lite_reg_file: inconsistent configuration");
  end

  // Any address bit above the register index makes the access out of range.
  function automatic logic addr_in_range(input logic [A_W-1:0] addr);
    return (addr >> HI_SHIFT) == A_W'(0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [A_W-1:0] addr);
    return IDX_W'(addr >> LSB);
  endfunction

  logic [D_W-1:0]              r_regs [N_REGS];
  logic [N_REGS-1:0]           r_wr_stb;
  logic                        r_rvalid;
  logic [D_W-1:0]              r_rdata;
  logic [1:0]                  r_rresp;

  logic                        w_commit_c;
  logic [A_W-1:0]              w_wr_addr;
  logic [D_W-1:0]              w_wr_data;
  logic [S_W-1:0]              w_wr_strb;
  logic                        w_wr_in_range;
  logic [IDX_W-1:0]            w_wr_idx;
  logic                        w_wr_en;
  logic                        w_arready;
  logic                        w_ar_hs;
  logic                        w_rd_in_range;
  logic [IDX_W-1:0]            w_rd_idx;
  logic [D_W-1:0]              w_rd_word;
  logic [N_REGS-1:0][D_W-1:0]  w_reg_d;

  // Write join and B channel.
  axi4_lite_wr_join #(
    .A_W (A_W),
    .D_W (D_W)
  ) u_wr_join (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .i_awvalid  (axi4_s.awvalid),
    .o_awready  (axi4_s.awready),
    .i_awaddr   (axi4_s.awaddr),
    .i_wvalid   (axi4_s.wvalid),
    .o_wready   (axi4_s.wready),
    .i_wdata    (axi4_s.wdata),
    .i_wstrb    (axi4_s.wstrb),
    .o_bvalid   (axi4_s.bvalid),
    .i_bready   (axi4_s.bready),
    .o_bresp    (axi4_s.bresp),
    .i_slverr   (~w_wr_in_range),
    .o_commit_c (w_commit_c),
    .o_addr     (w_wr_addr),
    .o_data     (w_wr_data),
    .o_strb     (w_wr_strb)
  );

  assign w_wr_in_range = addr_in_range(w_wr_addr);
  assign w_wr_idx      = addr_idx(w_wr_addr);
  // Read-only and out-of-range writes are answered but change nothing.
  assign w_wr_en       = w_commit_c & w_wr_in_range & ~RO_MASK[w_wr_idx];

  // Register array and write strobes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(N_REGS); i++) r_regs[i] <= RESET_VAL[i*D_W +: D_W];
      r_wr_stb <= '0;
    end else begin
      r_wr_stb <= '0;
      if (w_wr_en) begin
        r_regs[w_wr_idx]   <= D_W'(strb_merge(DATA_MAX_W'(r_regs[w_wr_idx]),
                                              DATA_MAX_W'(w_wr_data),
                                              STRB_MAX_W'(w_wr_strb)));
        r_wr_stb[w_wr_idx] <= 1'b1;
      end
    end
  end

  assign wr_stb = r_wr_stb;

  for (genvar i = 0; i < int'(N_REGS); i++) begin : g_reg_q
    assign reg_q[i*D_W +: D_W] = RO_MASK[i] ? '0 : r_regs[i];
  end

  // Read path: one beat per AR, data captured on the AR handshake edge, so a
  // same-edge write commit is not visible to that read.
  assign w_reg_d       = reg_d;
  assign w_arready     = aresetn & ~r_rvalid;
  assign w_ar_hs       = axi4_s.arvalid & w_arready;
  assign w_rd_in_range = addr_in_range(axi4_s.araddr);
  assign w_rd_idx      = addr_idx(axi4_s.araddr);
  assign w_rd_word     = RO_MASK[w_rd_idx] ? w_reg_d[w_rd_idx] : r_regs[w_rd_idx];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_in_range ? w_rd_word : '0;
      r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (axi4_s.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign axi4_s.arready = w_arready;
  assign axi4_s.rvalid  = r_rvalid;
  assign axi4_s.rdata   = r_rdata;
  assign axi4_s.rresp   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_reg_file.sv
// Self-checking bench for axi4_lite_reg_file (8 x 32-bit, register 5 read-only).
module tb_axi4_lite_reg_file;
  import axi4_lite_pkg::*;

  localparam int unsigned A_W    = 32;
  localparam int unsigned D_W    = 32;
  localparam int unsigned N_REGS = 8;
  localparam logic [N_REGS-1:0] RO_MASK = 8'b0010_0000;
  localparam logic [N_REGS*D_W-1:0] RESET_VAL =
    {32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hA5A5_0000, 32'h0, 32'h0};

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic [N_REGS*D_W-1:0] reg_q;
  logic [N_REGS*D_W-1:0] reg_d = '0;
  logic [N_REGS-1:0]     wr_stb;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0]  exp_b_q [$];
  r_exp_t      exp_r_q [$];
  logic [31:0] model [N_REGS];

  axi4_lite_if #(.A_W(A_W), .D_W(D_W)) bus ();

  axi4_lite_reg_file #(
    .A_W       (A_W),
    .D_W       (D_W),
    .N_REGS    (N_REGS),
    .RO_MASK   (RO_MASK),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi4_s  (bus),
    .reg_q   (reg_q),
    .reg_d   (reg_d),
    .wr_stb  (wr_stb)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] q_slice(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  function automatic logic [N_REGS*D_W-1:0] model_vec();
    logic [N_REGS*D_W-1:0] v;
    for (int i = 0; i < int'(N_REGS); i++) v[i*32 +: 32] = RO_MASK[i] ? 32'h0 : model[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(N_REGS); i++) model[i] = RESET_VAL[i*32 +: 32];
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Full write with AW and W offered together; returns the B response and
  // the strobe vector seen on the cycle bvalid rises.
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [7:0] stb);
    logic aw_hs, w_hs, aw_done, w_done;
    int n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.awvalid & bus.awready;
      w_hs  = bus.wvalid & bus.wready;
      tick();
      if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin bus.wvalid  = 1'b0; w_done  = 1'b1; end
      n++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    n_checks++;
    if (bus.bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL write_txn_bvalid addr=%h got=%b exp=1", addr, bus.bvalid);
    end
    resp = bus.bresp;
    stb  = wr_stb;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic read_txn(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic hs;
    int n;
    hs = 1'b0; n = 0;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
    while (!hs && n < 20) begin
      hs = bus.arready;
      tick();
      n++;
    end
    bus.arvalid = 1'b0;
    n_checks++;
    if (bus.rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_txn_rvalid addr=%h got=%b exp=1", addr, bus.rvalid);
    end
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    r_exp_t      e;
    aresetn = 1'b0;
    model_reset();
    repeat (3) tick();
    n_checks++; if (bus.awready !== 1'b0) begin n_fail++; $display("FAIL reset_awready got=%b exp=0", bus.awready); end
    n_checks++; if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL reset_wready got=%b exp=0", bus.wready); end
    n_checks++; if (bus.arready !== 1'b0) begin n_fail++; $display("FAIL reset_arready got=%b exp=0", bus.arready); end
    n_checks++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid got=%b exp=0", bus.bvalid); end
    n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); end
    n_checks++; if (wr_stb !== 8'h00) begin n_fail++; $display("FAIL reset_wr_stb got=%h exp=00", wr_stb); end
    n_checks++; if (reg_q !== model_vec()) begin n_fail++; $display("FAIL reset_reg_q got=%h exp=%h", reg_q, model_vec()); end
    aresetn = 1'b1;
    tick();
    n_checks++; if (bus.awready !== 1'b1) begin n_fail++; $display("FAIL post_reset_awready got=%b exp=1", bus.awready); end
    exp_r_q.push_back('{32'hA5A5_0000, RESP_OKAY});
    read_txn(32'h08, d, r);
    e = exp_r_q.pop_front();
    n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL reset_read_data got=%h exp=%h", d, e.data); end
    n_checks++; if (r !== e.resp) begin n_fail++; $display("FAIL reset_read_resp got=%b exp=%b", r, e.resp); end
  endtask

  task automatic test_aw_before_w();
    logic [1:0] eb;
    bus.awaddr = 32'h04; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++; if (bus.awready !== 1'b0) begin n_fail++; $display("FAIL awfirst_awready_c%0d got=%b exp=0", c, bus.awready); end
      if (c < 3) tick();
    end
    bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    exp_b_q.push_back(RESP_OKAY);
    model[1] = 32'h1234_5678;
    tick();
    bus.wvalid = 1'b0;
    n_checks++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL awfirst_bvalid_early got=%b exp=0", bus.bvalid); end
    n_checks++; if (q_slice(1) !== 32'h0) begin n_fail++; $display("FAIL awfirst_reg1_early got=%h exp=0", q_slice(1)); end
    tick();
    eb = exp_b_q.pop_front();
    n_checks++; if (q_slice(1) !== model[1]) begin n_fail++; $display("FAIL awfirst_reg1 got=%h exp=%h", q_slice(1), model[1]); end
    n_checks++; if (wr_stb !== 8'h02) begin n_fail++; $display("FAIL awfirst_wr_stb got=%h exp=02", wr_stb); end
    n_checks++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL awfirst_bvalid got=%b exp=1", bus.bvalid); end
    n_checks++; if (bus.bresp !== eb) begin n_fail++; $display("FAIL awfirst_bresp got=%b exp=%b", bus.bresp, eb); end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    n_checks++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL awfirst_bvalid_clear got=%b exp=0", bus.bvalid); end
    n_checks++; if (wr_stb !== 8'h00) begin n_fail++; $display("FAIL awfirst_wr_stb_pulse got=%h exp=00", wr_stb); end
  endtask

  task automatic test_strobe_w_first();
    logic [1:0] eb, r;
    logic [7:0] stb;
    bus.wdata = 32'h0000_0000; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    n_checks++; if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL wfirst_wready got=%b exp=0", bus.wready); end
    tick();
    bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
    exp_b_q.push_back(RESP_OKAY);
    model[3] = 32'hFF00_FF00;
    tick();
    bus.awvalid = 1'b0;
    n_checks++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL wfirst_bvalid_early got=%b exp=0", bus.bvalid); end
    tick();
    eb = exp_b_q.pop_front();
    n_checks++; if (q_slice(3) !== model[3]) begin n_fail++; $display("FAIL strobe_reg3 got=%h exp=%h", q_slice(3), model[3]); end
    n_checks++; if (wr_stb !== 8'h08) begin n_fail++; $display("FAIL strobe_wr_stb got=%h exp=08", wr_stb); end
    n_checks++; if (bus.bresp !== eb) begin n_fail++; $display("FAIL strobe_bresp got=%b exp=%b", bus.bresp, eb); end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    // Zero strobe: answered OKAY and pulses wr_stb, data untouched.
    exp_b_q.push_back(RESP_OKAY);
    write_txn(32'h0C, 32'h1234_5678, 4'h0, r, stb);
    eb = exp_b_q.pop_front();
    n_checks++; if (r !== eb) begin n_fail++; $display("FAIL zstrb_bresp got=%b exp=%b", r, eb); end
    n_checks++; if (stb !== 8'h08) begin n_fail++; $display("FAIL zstrb_wr_stb got=%h exp=08", stb); end
    n_checks++; if (q_slice(3) !== model[3]) begin n_fail++; $display("FAIL zstrb_reg3 got=%h exp=%h", q_slice(3), model[3]); end
  endtask

  task automatic test_back_pressure();
    logic [1:0] eb, held_resp;
    bus.bready = 1'b0;
    bus.awaddr = 32'h10; bus.wdata = 32'h1111_1111; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    exp_b_q.push_back(RESP_OKAY);
    model[4] = 32'h1111_1111;
    tick();
    bus.awaddr = 32'h40; bus.wdata = 32'h2222_2222;
    exp_b_q.push_back(RESP_SLVERR);
    tick();
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    held_resp = bus.bresp;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL bp_bvalid_c%0d got=%b exp=1", c, bus.bvalid); end
      n_checks++; if (bus.bresp !== held_resp) begin n_fail++; $display("FAIL bp_bresp_stable_c%0d got=%b exp=%b", c, bus.bresp, held_resp); end
      n_checks++; if (bus.awready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_c%0d awready got=%b exp=0", c, bus.awready); end
      tick();
    end
    n_checks++; if (q_slice(4) !== model[4]) begin n_fail++; $display("FAIL bp_reg4 got=%h exp=%h", q_slice(4), model[4]); end
    eb = exp_b_q.pop_front();
    n_checks++; if (bus.bresp !== eb) begin n_fail++; $display("FAIL bp_first_bresp got=%b exp=%b", bus.bresp, eb); end
    bus.bready = 1'b1;
    tick();
    eb = exp_b_q.pop_front();
    n_checks++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL bp_second_bvalid got=%b exp=1", bus.bvalid); end
    n_checks++; if (bus.bresp !== eb) begin n_fail++; $display("FAIL bp_second_bresp got=%b exp=%b", bus.bresp, eb); end
    n_checks++; if (wr_stb !== 8'h00) begin n_fail++; $display("FAIL bp_oor_wr_stb got=%h exp=00", wr_stb); end
    tick();
    bus.bready = 1'b0;
    n_checks++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_bvalid got=%b exp=0", bus.bvalid); end
    n_checks++; if (reg_q !== model_vec()) begin n_fail++; $display("FAIL bp_reg_q got=%h exp=%h", reg_q, model_vec()); end
  endtask

  task automatic test_oor_ro();
    logic [31:0] d;
    logic [1:0]  r, eb;
    logic [7:0]  stb;
    r_exp_t      e;
    exp_r_q.push_back('{32'h0, RESP_SLVERR});
    read_txn(32'h40, d, r);
    e = exp_r_q.pop_front();
    n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL oor_read_data got=%h exp=%h", d, e.data); end
    n_checks++; if (r !== e.resp) begin n_fail++; $display("FAIL oor_read_resp got=%b exp=%b", r, e.resp); end
    exp_b_q.push_back(RESP_SLVERR);
    write_txn(32'h40, 32'hCAFE_CAFE, 4'hF, r, stb);
    eb = exp_b_q.pop_front();
    n_checks++; if (r !== eb) begin n_fail++; $display("FAIL oor_write_resp got=%b exp=%b", r, eb); end
    n_checks++; if (stb !== 8'h00) begin n_fail++; $display("FAIL oor_write_stb got=%h exp=00", stb); end
    reg_d[5*32 +: 32] = 32'hDEAD_BEEF;
    exp_b_q.push_back(RESP_OKAY);
    write_txn(32'h14, 32'h1357_9BDF, 4'hF, r, stb);
    eb = exp_b_q.pop_front();
    n_checks++; if (r !== eb) begin n_fail++; $display("FAIL ro_write_resp got=%b exp=%b", r, eb); end
    n_checks++; if (stb !== 8'h00) begin n_fail++; $display("FAIL ro_write_stb got=%h exp=00", stb); end
    n_checks++; if (reg_q !== model_vec()) begin n_fail++; $display("FAIL ro_reg_q got=%h exp=%h", reg_q, model_vec()); end
    exp_r_q.push_back('{32'hDEAD_BEEF, RESP_OKAY});
    read_txn(32'h14, d, r);
    e = exp_r_q.pop_front();
    n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL ro_read_data got=%h exp=%h", d, e.data); end
    n_checks++; if (r !== e.resp) begin n_fail++; $display("FAIL ro_read_resp got=%b exp=%b", r, e.resp); end
    reg_d[5*32 +: 32] = 32'h0BAD_F00D;
    exp_r_q.push_back('{32'h0BAD_F00D, RESP_OKAY});
    read_txn(32'h14, d, r);
    e = exp_r_q.pop_front();
    n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL ro_live_data got=%h exp=%h", d, e.data); end
  endtask

  task automatic test_read_during_write();
    logic [31:0] d;
    logic [1:0]  r;
    r_exp_t      e;
    bus.awaddr = 32'h00; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0; bus.rready = 1'b0;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 32'h00; bus.arvalid = 1'b1;
    exp_r_q.push_back('{model[0], RESP_OKAY});
    model[0] = 32'h1;
    tick();
    bus.arvalid = 1'b0;
    e = exp_r_q.pop_front();
    n_checks++; if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL rdw_rvalid got=%b exp=1", bus.rvalid); end
    n_checks++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL rdw_bvalid got=%b exp=1", bus.bvalid); end
    n_checks++; if (q_slice(0) !== model[0]) begin n_fail++; $display("FAIL rdw_reg0 got=%h exp=%h", q_slice(0), model[0]); end
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (bus.rdata !== e.data) begin n_fail++; $display("FAIL rdw_rdata_c%0d got=%h exp=%h", c, bus.rdata, e.data); end
      tick();
    end
    bus.rready = 1'b1; bus.bready = 1'b1;
    tick();
    bus.rready = 1'b0; bus.bready = 1'b0;
    exp_r_q.push_back('{32'h1, RESP_OKAY});
    read_txn(32'h00, d, r);
    e = exp_r_q.pop_front();
    n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL rdw_reread got=%h exp=%h", d, e.data); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] eb;
    bus.awaddr = 32'h04; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    model_reset();
    n_checks++; if (bus.awready !== 1'b0) begin n_fail++; $display("FAIL midrst_awready got=%b exp=0", bus.awready); end
    n_checks++; if (reg_q !== model_vec()) begin n_fail++; $display("FAIL midrst_reg_q got=%h exp=%h", reg_q, model_vec()); end
    tick();
    aresetn = 1'b1;
    tick();
    bus.wdata = 32'h0000_0055; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_commit_c%0d got=%b exp=0", c, bus.bvalid); end
      tick();
    end
    bus.awaddr = 32'h04; bus.awvalid = 1'b1;
    exp_b_q.push_back(RESP_OKAY);
    model[1] = 32'h0000_0055;
    tick();
    bus.awvalid = 1'b0;
    tick();
    eb = exp_b_q.pop_front();
    n_checks++; if (bus.bresp !== eb || bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_b got=%b/%b exp=1/%b", bus.bvalid, bus.bresp, eb); end
    n_checks++; if (reg_q !== model_vec()) begin n_fail++; $display("FAIL midrst_final_reg_q got=%h exp=%h", reg_q, model_vec()); end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0;
    bus.wstrb = '0; bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0;
    bus.rready = 1'b0;
    test_reset();
    test_aw_before_w();
    test_strobe_w_first();
    test_back_pressure();
    test_oor_ro();
    test_read_during_write();
    test_reset_mid();
    n_checks++;
    if (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover b=%0d r=%0d exp=0/0", exp_b_q.size(), exp_r_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
